// File: rtl/motion_diff_scanner.sv
// motion_diff_scanner: walks the current/reference frame buffers in lockstep, feeds euclid_px_diff
// and reports motion count and max diff. Define MOTION_SUM_EN to build the diff_sum accumulator.
module motion_diff_scanner #(
  parameter int         ADDR_W = 17,
  parameter int         NUM_PX = 76800,
  parameter logic [7:0] THRESH = 8'd32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        cur_px,
  input  logic [7:0]        ref_px,
  output logic [7:0]        px1,
  output logic [7:0]        px2,
  input  logic [7:0]        diff,
  output logic [ADDR_W-1:0] motion_count,
  output logic [7:0]        max_diff,
  output logic [ADDR_W+7:0] diff_sum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PX - 1);

  state_t state;
  logic   drain_cnt;
  logic   cap_vld;
  logic   px_vld;
  logic   scan_clear;

  assign scan_clear = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rd_addr   <= '0;
          drain_cnt <= 1'b0;
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        READ: begin
          if (rd_addr == LAST_ADDR) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        // Two idle cycles let the last read reach px1/px2 and then the result registers.
        DRAIN: begin
          if (drain_cnt) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld <= 1'b0;
      px_vld  <= 1'b0;
      px1     <= '0;
      px2     <= '0;
    end else begin
      cap_vld <= rd_en;
      px_vld  <= cap_vld;
      if (cap_vld) begin
        px1 <= cur_px;
        px2 <= ref_px;
      end
    end
  end

  // Results persist after done and are only cleared when the next scan is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      motion_count <= '0;
      max_diff     <= '0;
    end else if (scan_clear) begin
      motion_count <= '0;
      max_diff     <= '0;
    end else if (px_vld) begin
      if (diff >= THRESH) begin
        motion_count <= motion_count + 1'b1;
      end
      if (diff > max_diff) begin
        max_diff <= diff;
      end
    end
  end

`ifdef MOTION_SUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_sum <= '0;
    end else if (scan_clear) begin
      diff_sum <= '0;
    end else if (px_vld) begin
      diff_sum <= diff_sum + {{ADDR_W{1'b0}}, diff};
    end
  end
`else
  assign diff_sum = '0;
`endif

endmodule

// File: tb/tb_motion_diff_scanner.sv
// Self-checking bench for motion_diff_scanner: randomized frames against a per-pixel reference
// model, plus directed timing, start-ignore, mid-scan reset and single-pixel cases.
module tb_motion_diff_scanner;

  localparam int         ADDR_W = 17;
  localparam int         NPX    = 4;
  localparam logic [7:0] THR    = 8'd32;
`ifdef MOTION_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        cur_px = '0, ref_px = '0;
  logic [7:0]        px1, px2, diff;
  logic [ADDR_W-1:0] motion_count;
  logic [7:0]        max_diff;
  logic [ADDR_W+7:0] diff_sum;

  logic              start_b = 1'b0;
  logic              busy_b, done_b, rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [7:0]        cur_px_b = '0, ref_px_b = '0;
  logic [7:0]        px1_b, px2_b, diff_b;
  logic [ADDR_W-1:0] motion_count_b;
  logic [7:0]        max_diff_b;
  logic [ADDR_W+7:0] diff_sum_b;

  logic [7:0] cur_mem [NPX];
  logic [7:0] ref_mem [NPX];
  logic [7:0] cur_b_val = '0, ref_b_val = '0;

  int tests_run = 0;
  int tests_failed = 0;

  motion_diff_scanner #(.ADDR_W(ADDR_W), .NUM_PX(NPX), .THRESH(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .cur_px(cur_px), .ref_px(ref_px), .px1(px1), .px2(px2), .diff(diff),
    .motion_count(motion_count), .max_diff(max_diff), .diff_sum(diff_sum)
  );

  motion_diff_scanner #(.ADDR_W(ADDR_W), .NUM_PX(1), .THRESH(THR)) dut_one (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .cur_px(cur_px_b), .ref_px(ref_px_b), .px1(px1_b), .px2(px2_b),
    .diff(diff_b), .motion_count(motion_count_b), .max_diff(max_diff_b), .diff_sum(diff_sum_b)
  );

  always #5 clk = ~clk;

  // Frame buffers with one cycle of read latency, and the external |a-b| difference unit.
  always @(posedge clk) begin
    if (rd_en) begin
      cur_px <= cur_mem[rd_addr[1:0]];
      ref_px <= ref_mem[rd_addr[1:0]];
    end
    if (rd_en_b) begin
      cur_px_b <= cur_b_val;
      ref_px_b <= ref_b_val;
    end
  end

  assign diff   = (px1 >= px2) ? px1 - px2 : px2 - px1;
  assign diff_b = (px1_b >= px2_b) ? px1_b - px2_b : px2_b - px1_b;

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NPX; i++) begin
      int a;
      int sel;
      a = int'($urandom_range(255, 0));
      sel = int'($urandom_range(3, 0));
      cur_mem[i] = 8'(a);
      case (sel)
        0:       ref_mem[i] = 8'(a);
        1:       ref_mem[i] = (a + 31 <= 255) ? 8'(a + 31) : 8'(a - 31);
        2:       ref_mem[i] = (a + 32 <= 255) ? 8'(a + 32) : 8'(a - 32);
        default: ref_mem[i] = 8'($urandom_range(255, 0));
      endcase
    end
  endtask

  task automatic loadFrames(input int c0, c1, c2, c3, r0, r1, r2, r3);
    cur_mem[0] = 8'(c0); cur_mem[1] = 8'(c1); cur_mem[2] = 8'(c2); cur_mem[3] = 8'(c3);
    ref_mem[0] = 8'(r0); ref_mem[1] = 8'(r1); ref_mem[2] = 8'(r2); ref_mem[3] = 8'(r3);
  endtask

  // Full scan on the 4-pixel instance; repulse adds start pulses in cycles 2, 7 and 8.
  task automatic runScan(input string tag, input bit repulse);
    int cyc;
    int d;
    int exp_mc;
    int exp_max;
    int exp_sum;
    exp_mc = 0; exp_max = 0; exp_sum = 0;
    for (int i = 0; i < NPX; i++) begin
      d = absDiff(int'(cur_mem[i]), int'(ref_mem[i]));
      if (d >= int'(THR)) exp_mc++;
      if (d > exp_max) exp_max = d;
      exp_sum += d;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      if (cyc <= NPX) begin
        checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd1);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'(cyc - 1));
      end else begin
        checkOutput({tag, "_rd_en_drain"}, 32'(rd_en), 32'd0);
      end
      start = repulse && (cyc == 2);
      tick();
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(NPX + 3));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_motion_count"}, 32'(motion_count), 32'(exp_mc));
    checkOutput({tag, "_max_diff"}, 32'(max_diff), 32'(exp_max));
    checkOutput({tag, "_diff_sum"}, 32'(diff_sum), SUM_EN ? 32'(exp_sum) : 32'd0);
    start = repulse;
    tick();
    start = 1'b0;
    checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hold_count"}, 32'(motion_count), 32'(exp_mc));
    checkOutput({tag, "_hold_max"}, 32'(max_diff), 32'(exp_max));
    if (repulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, "_restart_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_restart_clear"}, 32'(motion_count), 32'd0);
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      checkOutput({tag, "_restart_done_cycle"}, 32'(cyc), 32'(NPX + 3));
      checkOutput({tag, "_restart_count"}, 32'(motion_count), 32'(exp_mc));
      checkOutput({tag, "_restart_max"}, 32'(max_diff), 32'(exp_max));
      tick();
    end
  endtask

  task automatic runScanOne(input string tag, input int c, input int r);
    int cyc;
    int d;
    cur_b_val = 8'(c);
    ref_b_val = 8'(r);
    d = absDiff(c, r);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    while (done_b !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'd4);
    checkOutput({tag, "_motion_count"}, 32'(motion_count_b), (d >= int'(THR)) ? 32'd1 : 32'd0);
    checkOutput({tag, "_max_diff"}, 32'(max_diff_b), 32'(d));
    checkOutput({tag, "_diff_sum"}, 32'(diff_sum_b), SUM_EN ? 32'(d) : 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_px1", 32'(px1), 32'd0);
    checkOutput("rst_px2", 32'(px2), 32'd0);
    checkOutput("rst_motion_count", 32'(motion_count), 32'd0);
    checkOutput("rst_max_diff", 32'(max_diff), 32'd0);
    checkOutput("rst_diff_sum", 32'(diff_sum), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    loadFrames(10, 100, 50, 0, 10, 40, 50, 255);
    runScan("plan", 1'b0);

    loadFrames(7, 200, 0, 255, 7, 200, 0, 255);
    runScan("same", 1'b0);

    loadFrames(100, 100, 5, 5, 68, 69, 5, 5);
    runScan("thresh", 1'b0);

    applyStimulus();
    runScan("repulse", 1'b1);

    // Reset lands in cycle 3 while reads of large-difference pixels are in flight.
    loadFrames(0, 255, 0, 255, 255, 0, 255, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("midrst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("midrst_px1", 32'(px1), 32'd0);
    checkOutput("midrst_px2", 32'(px2), 32'd0);
    checkOutput("midrst_motion_count", 32'(motion_count), 32'd0);
    checkOutput("midrst_max_diff", 32'(max_diff), 32'd0);
    checkOutput("midrst_diff_sum", 32'(diff_sum), 32'd0);
    tick();
    tick();
    checkOutput("midrst_stale_count", 32'(motion_count), 32'd0);
    checkOutput("midrst_stale_max", 32'(max_diff), 32'd0);
    checkOutput("midrst_stale_busy", 32'(busy), 32'd0);
    applyStimulus();
    runScan("after_rst", 1'b0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      runScan("rand", 1'b0);
    end

    runScanOne("one_px", 0, 200);
    runScanOne("one_px_low", 200, 180);
    for (int k = 0; k < 4; k++) begin
      runScanOne("one_px_rand", int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/motion_diff_scanner.md
# motion_diff_scanner

Sequential front end for the `euclid_px_diff` pixel-difference unit. On `start` it walks the current-frame and reference-frame buffers in lockstep and drives each pixel pair onto `px1`/`px2`. It collects the returned `diff` and reports two results for the camera motion-detect path: how many pixels differ by at least `THRESH`, and the largest difference seen.

## Interface
Parameters:
- `ADDR_W`, 17, frame-buffer address width and width of `motion_count`
- `NUM_PX`, 76800, pixels per scan (320x240); must satisfy 1 <= `NUM_PX` <= 2^`ADDR_W`-1
- `THRESH`, 8'd32, a pixel counts as motion when `diff` >= `THRESH`

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a scan
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; results are valid in that cycle and after it
- `rd_en`  out  1  read strobe to both frame buffers
- `rd_addr`  out  `ADDR_W`  shared read address for both buffers
- `cur_px`  in  8  current-frame pixel, valid one cycle after `rd_en`
- `ref_px`  in  8  reference-frame pixel, valid one cycle after `rd_en`
- `px1`  out  8  registered current pixel, goes to `euclid_px_diff`
- `px2`  out  8  registered reference pixel, goes to `euclid_px_diff`
- `diff`  in  8  combinational difference returned from `euclid_px_diff`
- `motion_count`  out  `ADDR_W`  number of pixels with `diff` >= `THRESH`
- `max_diff`  out  8  largest `diff` seen in the scan
- `diff_sum`  out  `ADDR_W`+8  sum of all `diff` values (see Configuration)

## Operation
- FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE:
  - `start`=1 moves to READ.
  - Clears `motion_count`, `max_diff`, `diff_sum` and the address counter.
- READ:
  - `rd_en`=1 and `rd_addr`=n for n = 0..`NUM_PX`-1, one address per cycle.
  - After the address `NUM_PX`-1 cycle, moves to DRAIN.
- DRAIN: two cycles with `rd_en`=0, letting the pipeline empty, then moves to FINISH.
- FINISH: `done`=1 for one cycle, `busy`=0, then returns to IDLE.
- Pipeline stages:
  - Stage 1: issue the address.
  - Stage 2: buffer data arrives and is registered into `px1`/`px2`, tagged with a valid bit.
  - Stage 3: while the valid bit is set, sample `diff` and update the results.
- Result updates per valid pair:
  - `motion_count` += 1 if `diff` >= `THRESH`.
  - `max_diff` = max(`max_diff`, `diff`).
- Results hold their values after `done` until the next `start` is accepted.
- `start` while `busy`=1 is ignored and has no effect on the scan in progress.
- `start` in the FINISH cycle is ignored.
- Arithmetic:
  - All values are unsigned.
  - `motion_count` cannot overflow, given the `NUM_PX` bound.
  - `diff_sum` is sized for 255*`NUM_PX`, so it cannot overflow either.
- `rst` at any time, including mid-scan, forces IDLE on the next edge.
- Any buffer data still in flight after `rst` is discarded, because the valid bits are cleared.

## Timing
- Reset values:
  - `busy`, `done`, `rd_en` = 0.
  - `rd_addr`, `px1`, `px2` = 0.
  - `motion_count`, `max_diff`, `diff_sum` = 0.
  - State = IDLE.
- Cycle numbering: `start` is sampled high at edge E0, and cycle c starts at edge E(c-1).
- Read issue: `busy`=1 from cycle 1, and `rd_addr`=c-1 during cycles 1..`NUM_PX`.
- Data path:
  - Buffer data for address c-1 is present in cycle c+1.
  - That pixel appears on `px1`/`px2` in cycle c+2.
  - It is accumulated at the end of cycle c+2.
- Completion: `done`=1 in cycle `NUM_PX`+3, with `busy`=0 in that same cycle.
- Start-to-done latency is `NUM_PX`+3 cycles.
- Back-to-back operation:
  - A new `start` is accepted in the first IDLE cycle after FINISH.
  - The minimum period between scans is `NUM_PX`+4 cycles.
- `px1`/`px2` hold their last value while idle.

## Configuration
- `MOTION_SUM_EN` defined:
  - `diff_sum` accumulates every valid `diff`.
  - It is cleared on start acceptance and on `rst`.
- `MOTION_SUM_EN` undefined:
  - The `diff_sum` port still exists but is constant 0.
  - No accumulator is built.
  - All other behaviour is identical.

## Test plan
- `NUM_PX`=4, `THRESH`=32, diff model |a-b|, cur={10,100,50,0}, ref={10,40,50,255}:
  - `done` in cycle 7.
  - `motion_count`=2, `max_diff`=255.
  - `diff_sum`=315 with `MOTION_SUM_EN` defined; 0 without it.
- Identical frames (every cur=ref):
  - `motion_count`=0, `max_diff`=0.
  - `rd_addr` steps 0..3 in cycles 1..4.
- Pixel with diff exactly 32 versus exactly 31 (`THRESH`=32): `motion_count`=1.
- `start` re-pulsed in cycles 2 and 7:
  - The cycle-2 pulse is ignored; the cycle-7 pulse falls on FINISH and is ignored.
  - The first IDLE cycle is 8; `start` in cycle 8 produces `busy`=1 in cycle 9.
- `rst` asserted in cycle 3 of a scan:
  - The next cycle shows IDLE with all outputs 0.
  - A fresh `start` then gives a correct result, unaffected by stale pipeline data.
- `NUM_PX`=1, cur=0, ref=200: `done` in cycle 4, `motion_count`=1, `max_diff`=200.
